// File: rtl/axi_led_regs_if.sv
// AXI4 slave-side bundle for the LED register block: AW/W/B/AR/R channels.
interface axi_led_regs_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 40,
    parameter int ID_WIDTH   = 16
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_led_regs.sv
// AXI4 slave register file: reg0 drives LEDs, reg1 is a free-running counter,
// the rest are scratch. Independent single-outstanding read and write FSMs.
module axi_led_regs #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 40,
    parameter int                    ID_WIDTH   = 16,
    parameter int                    NUM_REGS   = 16,
    parameter int                    NUM_LEDS   = 8,
    parameter logic [DATA_WIDTH-1:0] LED_RESET  = 'hA5
) (
    input  logic                axi_clk,
    input  logic                axi_rst,
    axi_led_regs_if.slave       s_axi,
    output logic [NUM_LEDS-1:0] leds
);
    localparam int              NBYTES    = DATA_WIDTH / 8;
    localparam int              LSB       = $clog2(NBYTES);
    localparam int              IDXW      = $clog2(NUM_REGS);
    localparam logic [2:0]      FULL_SIZE = 3'(LSB);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_REGS - 1);
    localparam logic [1:0]      B_FIXED   = 2'b00;
    localparam logic [1:0]      B_INCR    = 2'b01;
    localparam logic [1:0]      OKAY      = 2'b00;
    localparam logic [1:0]      SLVERR    = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

    w_state_e            w_state_q, w_state_d;
    logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d;
    logic [IDXW-1:0]     widx_q, widx_d;
    logic [7:0]          wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic                wincr_q, wincr_d, wbad_q, wbad_d, woob_q, woob_d, werr_q, werr_d;
    logic                wbeat_err, wmismatch, wr_en;

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDXW-1:0]       ridx_q, ridx_d, ld_idx;
    logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic                  rincr_q, rincr_d, rbad_q, rbad_d, roob_q, roob_d;
    logic                  ld, ld_oob, ld_bad;

    logic unused_addr;
    assign unused_addr = ^{s_axi.awaddr, s_axi.araddr};

    // Narrow transfers and WRAP/reserved bursts error every beat.
    function automatic logic bad_req(logic [2:0] size, logic [1:0] burst);
        return (size != FULL_SIZE) || (burst != B_FIXED && burst != B_INCR);
    endfunction

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        wincr_d   = wincr_q;
        wbad_d    = wbad_q;
        woob_d    = woob_q;
        werr_d    = werr_q;
        wr_en     = 1'b0;
        wbeat_err = wbad_q | woob_q | (wbeat_q > wlen_q);
        wmismatch = s_axi.wlast && (wbeat_q != wlen_q);
        unique case (w_state_q)
            W_IDLE: if (awready_q && s_axi.awvalid) begin
                bid_d     = s_axi.awid;
                widx_d    = s_axi.awaddr[LSB +: IDXW];
                wlen_d    = s_axi.awlen;
                wbeat_d   = 8'd0;
                wincr_d   = (s_axi.awburst == B_INCR);
                wbad_d    = bad_req(s_axi.awsize, s_axi.awburst);
                woob_d    = 1'b0;
                werr_d    = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (wready_q && s_axi.wvalid) begin
                wr_en  = !wbeat_err;
                werr_d = werr_q | wbeat_err | wmismatch;
                if (wbeat_q != 8'hFF) wbeat_d = wbeat_q + 8'd1;
                if (wincr_q) begin
                    woob_d = woob_q | (widx_q == LAST_IDX);
                    widx_d = widx_q + IDXW'(1);
                end
                if (s_axi.wlast) begin
                    w_state_d = W_RESP;
                    bresp_d   = werr_d ? SLVERR : OKAY;
                end
            end
            W_RESP: if (bvalid_q && s_axi.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rincr_d   = rincr_q;
        rbad_d    = rbad_q;
        roob_d    = roob_q;
        ld        = 1'b0;
        ld_idx    = ridx_q;
        ld_oob    = roob_q;
        ld_bad    = rbad_q;
        unique case (r_state_q)
            R_IDLE: if (arready_q && s_axi.arvalid) begin
                rid_d     = s_axi.arid;
                rlen_d    = s_axi.arlen;
                rbeat_d   = 8'd0;
                rincr_d   = (s_axi.arburst == B_INCR);
                rlast_d   = (s_axi.arlen == 8'd0);
                ld        = 1'b1;
                ld_idx    = s_axi.araddr[LSB +: IDXW];
                ld_oob    = 1'b0;
                ld_bad    = bad_req(s_axi.arsize, s_axi.arburst);
                r_state_d = R_DATA;
            end
            R_DATA: if (rvalid_q && s_axi.rready) begin
                if (rlast_q) begin
                    rlast_d   = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    ld      = 1'b1;
                    rbeat_d = rbeat_q + 8'd1;
                    rlast_d = (rbeat_d == rlen_q);
                    ld_oob  = roob_q | (rincr_q && ridx_q == LAST_IDX);
                    if (rincr_q) ld_idx = ridx_q + IDXW'(1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // regs_q is sampled before this edge's write, so a colliding read sees old data.
        if (ld) begin
            ridx_d  = ld_idx;
            roob_d  = ld_oob;
            rbad_d  = ld_bad;
            rdata_d = (ld_bad || ld_oob) ? '0 : regs_q[ld_idx];
            rresp_d = (ld_bad || ld_oob) ? SLVERR : OKAY;
        end
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= 8'd0;
            wbeat_q   <= 8'd0;
            wincr_q   <= 1'b0;
            wbad_q    <= 1'b0;
            woob_q    <= 1'b0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rid_q     <= '0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= 8'd0;
            rbeat_q   <= 8'd0;
            rincr_q   <= 1'b0;
            rbad_q    <= 1'b0;
            roob_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wincr_q   <= wincr_d;
            wbad_q    <= wbad_d;
            woob_q    <= woob_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rincr_q   <= rincr_d;
            rbad_q    <= rbad_d;
            roob_q    <= roob_d;
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            regs_q    <= '0;
            regs_q[0] <= LED_RESET;
        end else begin
            regs_q[1] <= regs_q[1] + DATA_WIDTH'(1);
            if (wr_en && widx_q != IDXW'(1)) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (s_axi.wstrb[b]) regs_q[widx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rdata   = rdata_q;
    assign leds          = regs_q[0][NUM_LEDS-1:0];
endmodule

// File: doc/axi_led_regs.md
# axi_led_regs

AXI4 slave register block for the Zynq PL master port, replacing the constant-response tie-offs on `m_axi_*` with a real, protocol-correct responder. It holds a small register file in the `axi_clk` domain. Register 0 drives the board LEDs, register 1 is a free-running cycle counter, and the remaining registers are scratch. It supports FIXED/INCR bursts, byte strobes, and error responses, so software can exercise the PS-PL path end to end.

## Interface
Parameters:
- `DATA_WIDTH`, 64: AXI data width; must be 32, 64 or 128.
- `ADDR_WIDTH`, 40: AXI address width.
- `ID_WIDTH`, 16: AXI ID width.
- `NUM_REGS`, 16: register count; power of two, ≥4.
- `NUM_LEDS`, 8: LED count; ≤ `DATA_WIDTH`.
- `LED_RESET`, 'hA5: reset value of register 0, and therefore of `leds`.

Ports:
- `axi_clk`  in  1  sole clock.
- `axi_rst`  in  1  reset, asynchronous, active-high.
- `s_axi_awid/awaddr/awlen/awsize/awburst`  in  `ID_WIDTH`/`ADDR_WIDTH`/8/3/2  write address.
- `s_axi_awvalid` in 1; `s_axi_awready` out 1.
- `s_axi_wdata/wstrb/wlast/wvalid`  in  `DATA_WIDTH`/`DATA_WIDTH/8`/1/1; `s_axi_wready` out 1.
- `s_axi_bid/bresp/bvalid`  out  `ID_WIDTH`/2/1; `s_axi_bready` in 1.
- `s_axi_arid/araddr/arlen/arsize/arburst/arvalid`  in  as AW; `s_axi_arready` out 1.
- `s_axi_rid/rdata/rresp/rlast/rvalid`  out  `ID_WIDTH`/`DATA_WIDTH`/2/1/1; `s_axi_rready` in 1.
- `leds`  out  `NUM_LEDS`  equals `reg0[NUM_LEDS-1:0]`, driven straight from the flop.

## Operation
- Decode: word index = `addr[LSB +: log2(NUM_REGS)]`, where `LSB = log2(DATA_WIDTH/8)`. Upper address bits are ignored, so the register file aliases.
- Map:
  - reg0: LED/RW.
  - reg1: counter, read-only; writes are dropped but still return OKAY. It increments every cycle and wraps modulo 2^`DATA_WIDTH`.
  - reg2..`NUM_REGS-1`: RW scratch.
- Burst error rules; any of these gives SLVERR (2'b10) for the affected beats:
  - `awsize`/`arsize` ≠ full width: all beats.
  - WRAP burst: all beats.
  - INCR beat whose index steps past `NUM_REGS-1`: that beat and all later beats.
- Burst address stepping: FIXED holds the index; INCR adds 1 per beat. An errored write beat has no effect. An errored read beat returns `rdata`=0.
- Write FSM:
  - W_IDLE (`awready`=1): on AW handshake, latch ID, index, len and burst, then go to W_DATA.
  - W_DATA (`wready`=1): each W handshake writes the bytes enabled by `wstrb`. On `wlast`, go to W_RESP.
  - W_RESP (`bvalid`=1, `bid`=latched ID): `bresp` = SLVERR if any beat errored, else OKAY. On `bready`, return to W_IDLE.
  - `wlast` is trusted over `awlen`. A mismatch forces SLVERR, with no further beats accepted.
- Read FSM:
  - R_IDLE (`arready`=1): on AR handshake, go to R_DATA.
  - R_DATA: the beat counter runs 0..`arlen`. `rlast` is high on beat `arlen`. On that beat's handshake, return to R_IDLE.
- Read and write FSMs are independent, and each accepts one outstanding transaction.
- Same-cycle read beat load and write to the same register: the read returns the pre-write value.

## Timing
- Reset values:
  - `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast` = 0.
  - `bresp`, `rresp`, `rdata`, `bid`, `rid` = 0.
  - reg0 = `LED_RESET`; reg1 = 0; scratch registers = 0.
  - `leds` = `LED_RESET`.
- `awready` and `arready` rise in the first cycle after `axi_rst` deasserts.
- All outputs are registered.
- Write latency: AW handshake at cycle N → `wready` at N+1. Last W handshake at M → register updated and `bvalid` at M+1.
- Read latency: AR handshake at N → beat 0 valid at N+1. Each subsequent beat is valid the cycle after the previous handshake. Throughput is 1 beat/cycle while `rready`=1.
- `rvalid`/`bvalid` and their payloads hold stable while ready is low.
- `axi_rst` asserted mid-burst: both FSMs return to IDLE, all valids drop immediately, and no response is owed for the aborted transaction.

## Test plan
- Reset release → `leds`=8'hA5; `awready`=`arready`=1 one cycle later; reg1 reads a small nonzero value that increases on each read.
- Single write of 64'h3C to reg0 with `wstrb`=8'h01 → `bresp`=OKAY, `leds`=8'h3C; readback returns 64'h3C.
- INCR write, `awlen`=3, starting at reg2, data 1..4 → reg2..5 = 1..4. Then an INCR read with `arlen`=3 and `rready` toggling every other cycle → data 1..4 in order, `rlast` only on the 4th beat.
- INCR read starting at reg `NUM_REGS-2`, `arlen`=3 → beats 0–1 OKAY with data; beats 2–3 SLVERR with `rdata`=0.
- WRAP burst, or `awsize`=2 with `DATA_WIDTH`=64 → `bresp`=SLVERR and registers unchanged. Write to reg1 → OKAY, and the counter keeps running.
- Assert `axi_rst` during beat 2 of a 4-beat read → `rvalid`=0 at once; after release, a fresh read succeeds and `leds`=8'hA5.
